// File: rtl/biquad_pkg.sv
// Shared widths, FSM encoding and saturation constant for the biquad magnitude datapath.
// The multiplier and the divider both import this package.
package biquad_pkg;

  localparam int DATAWIDTH = 16;
  localparam int COEFWIDTH = 16;
  localparam int QW = DATAWIDTH - 1;
  localparam int CW = COEFWIDTH - 1;
  localparam int NW = DATAWIDTH + COEFWIDTH - 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [QW-1:0] Q_SAT = '1;

endpackage

// File: rtl/divb_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
// The partial remainder carries one spare bit so the compare cannot overflow.
module divb_step #(
  parameter int CW = 15
) (
  input  logic [CW:0]   p,
  input  logic          sbit,
  input  logic [CW-1:0] d,
  output logic [CW:0]   p_next,
  output logic          qbit
);

  logic [CW:0] t;
  logic [CW:0] d_ext;

  always_comb begin
    t      = {p[CW-1:0], sbit};
    d_ext  = {1'b0, d};
    qbit   = (t >= d_ext);
    p_next = qbit ? (t - d_ext) : t;
  end

endmodule

// File: rtl/divb_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// start/busy/done handshake; divide-by-zero and quotient overflow finish immediately.
module divb_seq
  import biquad_pkg::*;
#(
  parameter int DATAWIDTH = biquad_pkg::DATAWIDTH,
  parameter int COEFWIDTH = biquad_pkg::COEFWIDTH
) (
  input  logic                                clk,
  input  logic                                nreset,
  input  logic                                start,
  input  logic [DATAWIDTH+COEFWIDTH-3:0]      n,
  input  logic [COEFWIDTH-2:0]                d,
  output logic                                busy,
  output logic                                done,
  output logic [DATAWIDTH-2:0]                q,
  output logic [COEFWIDTH-2:0]                rem,
  output logic                                ovf,
  output logic                                dz,
  output state_e                              dbg_state
);

  // Handshake: start is accepted at a rising edge only when busy=0 (IDLE or DONE);
  // busy is high exactly while in RUN; done pulses for one cycle and q/rem/ovf/dz
  // are valid from that cycle and held until the next completion.

  localparam int LQW  = DATAWIDTH - 1;
  localparam int LCW  = COEFWIDTH - 1;
  localparam int LNW  = DATAWIDTH + COEFWIDTH - 2;
  localparam int CNTW = (LQW > 1) ? $clog2(LQW) : 1;

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [LCW:0]    p_q, p_d;
  logic [LQW-1:0]  s_q, s_d;
  logic [LCW-1:0]  dv_q, dv_d;
  logic [LQW-1:0]  q_q, q_d;
  logic [LCW-1:0]  rem_q, rem_d;
  logic            ovf_q, ovf_d;
  logic            dz_q, dz_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [LCW:0]    step_p;
  logic            step_bit;
  logic [LCW-1:0]  n_upper;

  assign n_upper = n[LNW-1:LQW];

  divb_step #(.CW(LCW)) u_step (
    .p      (p_q),
    .sbit   (s_q[LQW-1]),
    .d      (dv_q),
    .p_next (step_p),
    .qbit   (step_bit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    s_d     = s_q;
    dv_d    = dv_q;
    q_d     = q_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          dv_d = d;
          if (d == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            dz_d    = 1'b1;
            ovf_d   = 1'b0;
            q_d     = '1;
            rem_d   = '0;
          end else if (n_upper >= d) begin
            state_d = DONE;
            done_d  = 1'b1;
            dz_d    = 1'b0;
            ovf_d   = 1'b1;
            q_d     = '1;
            rem_d   = '0;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
            p_d     = {1'b0, n_upper};
            s_d     = n[LQW-1:0];
            cnt_d   = CNTW'(LQW - 1);
          end
        end
      end
      RUN: begin
        p_d = step_p;
        s_d = {s_q[LQW-2:0], step_bit};
        if (cnt_q == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
          q_d     = {s_q[LQW-2:0], step_bit};
          rem_d   = step_p[LCW-1:0];
          ovf_d   = 1'b0;
          dz_d    = 1'b0;
        end else begin
          busy_d = 1'b1;
          cnt_d  = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      s_q     <= '0;
      dv_q    <= '0;
      q_q     <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      s_q     <= s_d;
      dv_q    <= dv_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign q         = q_q;
  assign rem       = rem_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_divb_seq.sv
// Bench for divb_seq: directed vector table, random inverse/identity checks,
// and hand-written sequences for start-while-busy, back-to-back and mid-divide reset.
module tb_divb_seq;
  import biquad_pkg::*;

  logic        clk;
  logic        nreset;
  logic        start;
  logic [29:0] n_i;
  logic [14:0] d_i;
  logic        busy;
  logic        done;
  logic [14:0] q;
  logic [14:0] rem;
  logic        ovf;
  logic        dz;
  state_e      dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  divb_seq dut (
    .clk       (clk),
    .nreset    (nreset),
    .start     (start),
    .n         (n_i),
    .d         (d_i),
    .busy      (busy),
    .done      (done),
    .q         (q),
    .rem       (rem),
    .ovf       (ovf),
    .dz        (dz),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] n;
    logic [14:0] d;
    logic [14:0] q;
    logic [14:0] r;
    logic        ovf;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Accept a divide, then wait (bounded) for done; returns edges from accept and busy cycles seen.
  task automatic run_div(input logic [29:0] nn, input logic [14:0] dd,
                         output int lat, output int busy_n);
    @(negedge clk);
    n_i = nn; d_i = dd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; busy_n = 0;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  int lat, busy_n, pulses;
  logic [14:0] ra, rb, rd;
  logic [29:0] rn;

  initial begin
    nreset = 1'b0; start = 1'b0; n_i = '0; d_i = '0;
    vecs[0] = '{30'd1000,       15'd7,     15'd142,    15'd6,      1'b0, 1'b0, 16};
    vecs[1] = '{30'd12345,      15'd0,     15'h7FFF,   15'd0,      1'b0, 1'b1, 1};
    vecs[2] = '{30'h0000_8000,  15'd1,     15'h7FFF,   15'd0,      1'b1, 1'b0, 1};
    vecs[3] = '{30'h0000_7FFF,  15'd1,     15'h7FFF,   15'd0,      1'b0, 1'b0, 16};
    vecs[4] = '{30'd100,        15'd10,    15'd10,     15'd0,      1'b0, 1'b0, 16};
    vecs[5] = '{30'd0,          15'd5,     15'd0,      15'd0,      1'b0, 1'b0, 16};
    vecs[6] = '{30'h3FFF_7FFF,  15'h7FFF,  15'h7FFF,   15'h7FFE,   1'b0, 1'b0, 16};
    vecs[7] = '{30'h3FFF_FFFF,  15'h7FFF,  15'h7FFF,   15'd0,      1'b1, 1'b0, 1};
    vecs[8] = '{30'd1000,       15'd1000,  15'd1,      15'd0,      1'b0, 1'b0, 16};
    vecs[9] = '{30'd65535,      15'd256,   15'd255,    15'd255,    1'b0, 1'b0, 16};

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_q", q, 0);
    check("reset_rem", rem, 0);
    check("reset_flags", {ovf, dz}, 0);
    check("reset_state", dbg_state, IDLE);
    @(negedge clk);
    nreset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_div(vecs[i].n, vecs[i].d, lat, busy_n);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_busy_cycles", i), busy_n, vecs[i].lat - 1);
      check($sformatf("vec%0d_q", i), q, vecs[i].q);
      check($sformatf("vec%0d_rem", i), rem, vecs[i].r);
      check($sformatf("vec%0d_ovf", i), ovf, vecs[i].ovf);
      check($sformatf("vec%0d_dz", i), dz, vecs[i].dz);
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_pulse", i), done, 0);
    end

    // Inverse of the multiplier: (a*b)/a must give b exactly.
    for (int i = 0; i < 1000; i++) begin
      ra = 15'($urandom_range(1, 32767));
      rb = 15'($urandom_range(0, 32767));
      rn = 30'(ra) * 30'(rb);
      run_div(rn, ra, lat, busy_n);
      check("inv_q", q, rb);
      check("inv_rem", rem, 0);
    end

    for (int i = 0; i < 200; i++) begin
      rd = 15'($urandom_range(1, 32767));
      rn = {15'($urandom_range(0, int'(rd) - 1)), 15'($urandom_range(0, 32767))};
      run_div(rn, rd, lat, busy_n);
      check("rand_identity", longint'(q) * longint'(rd) + longint'(rem), longint'(rn));
      check("rand_rem_lt_d", rem < rd, 1);
      check("rand_flags", {ovf, dz}, 0);
    end

    // Start while busy is ignored.
    @(negedge clk);
    n_i = 30'd1000; d_i = 15'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 1;
    while (!done && lat < 40) begin
      if (lat == 4) begin n_i = 30'd50; d_i = 15'd3; start = 1'b1; end
      if (lat == 5) start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check("busy_start_latency", lat, 16);
    check("busy_start_q", q, 142);
    check("busy_start_rem", rem, 6);

    // Start during the DONE cycle is accepted back-to-back.
    n_i = 30'd100; d_i = 15'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_latency", lat, 16);
    check("b2b_q", q, 10);
    check("b2b_rem", rem, 0);

    // Reset mid-divide aborts with no done pulse.
    @(negedge clk);
    n_i = 30'd1000; d_i = 15'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 1;
    while (lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    nreset = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_q", q, 0);
    check("abort_rem", rem, 0);
    nreset = 1'b1;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("abort_no_done", pulses, 0);
    run_div(30'd1000, 15'd7, lat, busy_n);
    check("post_reset_latency", lat, 16);
    check("post_reset_q", q, 142);
    check("post_reset_rem", rem, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
